bram32_arbiter: RTL
===================

BRAM32_ARBITER -- requirements
Module: bram32_arbiter

Interface
REQ-001 The module SHALL expose parameter RR_EN, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority with port 0 highest.
REQ-002 The module SHALL expose the following ports, clock and reset first:
- sys_clk  in  1  sole clock; all state updates on the rising edge.
- sys_rst  in  1  reset; asynchronous, active-low.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write enable; 1 = write, 0 = read.
- p0_a  in  16  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_ack  out  1  port 0 completion pulse.
- p0_rdata  out  32  port 0 read data.
- p1_req, p1_we, p1_a, p1_wdata, p1_ack, p1_rdata  port 1 equivalents, same directions and widths.
- ram_a  out  16  address to RAM.
- ram_do  out  32  write data to RAM.
- ram_we  out  1  RAM write strobe.
- ram_di  in  32  RAM read data, registered in the RAM with 1-cycle latency.
- grant  out  2  one-hot owner of the current access; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The controller SHALL be a 4-state FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-004 In IDLE with at least one req high, the controller SHALL pick a winner and register ram_a, ram_do, ram_we (= winner's we) and grant, then enter ISSUE.
REQ-005 In IDLE with no req high, the controller SHALL stay in IDLE with ram_we=0 and grant=00.
REQ-006 With RR_EN=1 and both req high, the controller SHALL grant the port not granted last; with a single requester, that requester SHALL win regardless of history.
REQ-007 With RR_EN=0 and both req high, port 0 SHALL always win.
REQ-008 ram_we SHALL be high only during the ISSUE cycle, for exactly one clock per write, and never for reads.
REQ-009 ram_a and ram_do SHALL hold stable from ISSUE through DONE.
REQ-010 In WAIT, the controller SHALL capture ram_di into the winner's rdata register.
REQ-011 In DONE, the winner's ack SHALL be high for exactly one cycle, with its rdata valid in that cycle.
REQ-012 Latency SHALL be fixed: req sampled in cycle N gives ack in cycle N+3.
REQ-013 Maximum throughput SHALL be one access per 4 cycles.
REQ-014 For a write, rdata SHALL return the pre-write word, because the RAM is read-first.
REQ-015 Each rdata SHALL hold its value until that port's next completed access.
REQ-016 The losing port SHALL receive no ack and SHALL be serviced in the next IDLE if its req is still high.
REQ-017 A requester SHALL hold req, we, a and wdata stable until ack, and SHALL drop req in the cycle after ack or present a new request.
REQ-018 A req still high in the IDLE cycle following DONE SHALL be treated as a new access.
REQ-019 Address, write data and we SHALL be sampled only in IDLE; changes during ISSUE through DONE SHALL be ignored.
REQ-020 Only one ack SHALL be high in any cycle, and p0_ack and p1_ack SHALL never be high simultaneously.
REQ-021 The round-robin pointer SHALL update only on grant in IDLE.

Reset
REQ-022 While sys_rst=0, asynchronously and regardless of clock: state SHALL be IDLE; ram_we, ram_a, ram_do, grant, busy, p0_ack, p1_ack, p0_rdata and p1_rdata SHALL be 0; and the last-grant pointer SHALL be port 1, so port 0 wins the first tie.
REQ-023 Reset asserted mid-access SHALL abort the access with no ack issued.
REQ-024 Reset asserted before the ISSUE-cycle clock edge SHALL suppress the write.
REQ-025 After release, the first rising edge with sys_rst=1 SHALL evaluate IDLE normally.

Verification
REQ-026 Single write then read: p0 writes 0xDEADBEEF to 0x0010, then p0 reads 0x0010 -> ram_we high for exactly one cycle, read ack at N+3 with p0_rdata=0xDEADBEEF.
REQ-027 Simultaneous requests after reset with RR_EN=1, both req held through two accesses: p0 reads 0x0000 and p1 reads 0x0004 -> p0 acked first at cycle 3, p1 acked at cycle 7, grant 01 then 10.
REQ-028 Fairness with RR_EN=1: both ports request continuously for 8 accesses -> grants strictly alternate, each port receives 4 acks, and acks are never simultaneous.
REQ-029 Fixed priority with RR_EN=0: both ports request continuously -> p0 receives every ack and p1 receives none until p0 drops req; p1 is then acked 3 cycles after the following IDLE.
REQ-030 Reset mid-write: p1 writes 0x12345678 to 0x0020 and sys_rst is pulled low during ISSUE before the clock edge -> no ack, all outputs 0, and a subsequent read of 0x0020 returns the old value.
REQ-031 Write read-first: 0x0008 preloaded with 0x00000001, then p0 writes 0xAAAAAAAA to 0x0008 -> p0_rdata=0x00000001 at ack, and a following read returns 0xAAAAAAAA.

Source files
------------

// File: rtl/bram32_arbiter.sv
// bram32_arbiter
//   Two-port arbiter in front of one single-port 32-bit RAM. The RAM is
//   read-first and returns ram_di one clock after it samples ram_a. Every
//   access walks IDLE -> ISSUE -> WAIT -> DONE, so an access completes every
//   4 cycles at best. A request sampled in IDLE is acked 3 cycles later.
//
//   Parameter RR_EN: 1 = round-robin on ties, 0 = fixed priority (port 0 wins).
//
//   Ports
//     sys_clk, sys_rst            clock; asynchronous active-low reset
//     pN_req/we/a/wdata (N=0,1)   request, write enable, byte address, write data
//     pN_ack, pN_rdata            one-cycle completion pulse, read data (held)
//     ram_a, ram_do, ram_we       registered address, write data, write strobe
//     ram_di                      RAM read data (1-cycle registered latency)
//     grant                       one-hot owner of the current access, 00 idle
//     busy                        controller is not in IDLE

// Per-port completion slot. It captures read data and raises ack the cycle
// after the WAIT-state capture strobe, then holds rdata until the next capture.
module bram32_port_slot (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cap,
  input  logic [31:0] ram_di,
  output logic        ack,
  output logic [31:0] rdata
);
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= cap;
      if (cap) rdata <= ram_di;
    end
  end
endmodule

module bram32_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_a,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_a,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic [15:0] ram_a,
  output logic [31:0] ram_do,
  output logic        ram_we,
  input  logic [31:0] ram_di,
  output logic [1:0]  grant,
  output logic        busy
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [31:0] wdata;
  } port_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                          state_q, state_d;
  logic      [NUM_PORTS-1:0]       req, win, cap, ack;
  logic      [NUM_PORTS-1:0][31:0] rdata;
  port_req_t [NUM_PORTS-1:0]       preq;
  port_req_t                       sel;
  logic                            last_q;  // 1 = port 1 owned the last grant

  assign req     = {p1_req, p0_req};
  assign preq[0] = {p0_we, p0_a, p0_wdata};
  assign preq[1] = {p1_we, p1_a, p1_wdata};

  // Winner select. On a tie, round-robin hands the grant to whichever port
  // did not get it last; fixed priority always favours port 0.
  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (RR_EN != 0 && !last_q) ? 2'b10 : 2'b01;
      default: win = '0;
    endcase
  end

  assign sel = win[1] ? preq[1] : preq[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only in IDLE, so the requester's inputs are
  // don't-care until the next IDLE. ram_we lives for the ISSUE cycle only;
  // an async reset during ISSUE clears it before the RAM's sampling edge.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      ram_a   <= '0;
      ram_do  <= '0;
      ram_we  <= 1'b0;
      grant   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (|req) begin
          ram_a  <= sel.a;
          ram_do <= sel.wdata;
          ram_we <= sel.we;
          grant  <= win;
          last_q <= win[1];
        end
        ISSUE:   ram_we <= 1'b0;
        DONE:    grant  <= '0;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  // ram_di carries the addressed word (pre-write for writes) during WAIT.
  assign cap  = (state_q == WAIT) ? grant : '0;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    bram32_port_slot u_slot (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .cap     (cap[i]),
      .ram_di  (ram_di),
      .ack     (ack[i]),
      .rdata   (rdata[i])
    );
  end

  assign p0_ack   = ack[0];
  assign p1_ack   = ack[1];
  assign p0_rdata = rdata[0];
  assign p1_rdata = rdata[1];
endmodule
